// File: rtl/keystream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : keystream_buffer
// Description : Buffered keystream source. Fills DEPTH words from a seeded
//               Galois LFSR and hands them out one per request, with an
//               optional automatic refill on exhaustion, a dropped-request
//               pulse and a remaining-word count.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1                  clock, rising edge
//   rst_n        in   1                  asynchronous active-low reset
//   seed_load_i  in   1                  load seed, discard buffer, go idle
//   seed_i       in   WIDTH              seed value (0 is mapped to 1)
//   req_i        in   1                  request next keystream word
//   ready_o      out  1                  a req this cycle will be accepted
//   out_valid_o  out  1                  1-cycle pulse, out_data_o valid
//   out_data_o   out  WIDTH              keystream word, held between pulses
//   exhausted_o  out  1                  buffer used up, waiting
//   req_drop_o   out  1                  1-cycle pulse, a req was refused
//   words_left_o out  $clog2(DEPTH+1)    unconsumed words in the buffer
// ============================================================================

package types_pkg;
  typedef enum logic [2:0] {
    H_GROUND      = 3'd0,
    H_FIRST_QUERY = 3'd1,
    H_READY       = 3'd2,
    H_QUERIED     = 3'd3,
    H_PULSE_OUT   = 3'd4,
    H_EXHAUSTED   = 3'd5
  } hash_generator_state_t;
endpackage

module keystream_buffer
  import types_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] POLY        = 8'hB8,
  parameter bit               AUTO_REFILL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       seed_load_i,
  input  logic [WIDTH-1:0]           seed_i,
  input  logic                       req_i,
  output logic                       ready_o,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  output logic                       exhausted_o,
  output logic                       req_drop_o,
  output logic [$clog2(DEPTH+1)-1:0] words_left_o
);

  localparam int             MW       = $clog2(DEPTH);
  localparam int             CW       = $clog2(DEPTH+1);
  localparam logic [MW-1:0]  LAST_IDX = MW'(DEPTH - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  hash_generator_state_t state_q, state_d;

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [MW-1:0]    marker_q, marker_d;
  logic [MW-1:0]    fill_q, fill_d;
  // Set when the fill was started by a request from H_GROUND, so that the
  // pending request is served once the buffer is full. Clear for refills.
  logic             serve_q, serve_d;
  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [WIDTH-1:0] buf_d [DEPTH];
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             req_drop_q, req_drop_d;
  logic [CW-1:0]    words_left_q, words_left_d;

  logic             ready_w;
  logic [WIDTH-1:0] step_w;

  assign ready_w = (state_q == H_GROUND) || (state_q == H_READY);
  assign step_w  = lfsr_step(lfsr_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= H_GROUND;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q       <= {{(WIDTH-1){1'b0}}, 1'b1};
      marker_q     <= '0;
      fill_q       <= '0;
      serve_q      <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      req_drop_q   <= 1'b0;
      words_left_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      lfsr_q       <= lfsr_d;
      marker_q     <= marker_d;
      fill_q       <= fill_d;
      serve_q      <= serve_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      req_drop_q   <= req_drop_d;
      words_left_q <= words_left_d;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    marker_d     = marker_q;
    fill_d       = fill_q;
    serve_d      = serve_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    words_left_d = words_left_q;
    for (int i = 0; i < DEPTH; i++) begin
      buf_d[i] = buf_q[i];
    end
    // A req is never queued; a refused one is flagged on the next cycle.
    // A seed load overrides everything, including this flag.
    req_drop_d   = req_i && !ready_w && !seed_load_i;

    if (seed_load_i) begin
      // An all-zero seed would lock the LFSR at zero.
      lfsr_d       = (seed_i == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed_i;
      marker_d     = '0;
      fill_d       = '0;
      serve_d      = 1'b0;
      words_left_d = '0;
      state_d      = H_GROUND;
    end else begin
      case (state_q)
        H_GROUND: begin
          if (req_i) begin
            fill_d  = '0;
            serve_d = 1'b1;
            state_d = H_FIRST_QUERY;
          end
        end
        H_FIRST_QUERY: begin
          buf_d[fill_q] = step_w;
          lfsr_d        = step_w;
          fill_d        = fill_q + 1'b1;
          if (fill_q == LAST_IDX) begin
            fill_d       = '0;
            marker_d     = '0;
            serve_d      = 1'b0;
            words_left_d = FULL_CNT;
            state_d      = serve_q ? H_QUERIED : H_READY;
          end
        end
        H_READY: begin
          if (req_i) begin
            state_d = H_QUERIED;
          end
        end
        H_QUERIED: begin
          out_data_d = buf_q[marker_q];
          state_d    = H_PULSE_OUT;
        end
        H_PULSE_OUT: begin
          out_valid_d  = 1'b1;
          words_left_d = words_left_q - 1'b1;
          if (marker_q == LAST_IDX) begin
            marker_d = '0;
            state_d  = H_EXHAUSTED;
          end else begin
            marker_d = marker_q + 1'b1;
            state_d  = H_READY;
          end
        end
        H_EXHAUSTED: begin
          if (AUTO_REFILL) begin
            // Refill continues the LFSR sequence; no word is served.
            fill_d   = '0;
            serve_d  = 1'b0;
            marker_d = '0;
            state_d  = H_FIRST_QUERY;
          end
        end
        default: begin
          marker_d     = '0;
          fill_d       = '0;
          serve_d      = 1'b0;
          words_left_d = '0;
          state_d      = H_GROUND;
        end
      endcase
    end
  end

  assign ready_o      = ready_w;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign exhausted_o  = (state_q == H_EXHAUSTED);
  assign req_drop_o   = req_drop_q;
  assign words_left_o = words_left_q;

endmodule

`default_nettype wire

// File: tb/tb_keystream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_keystream_buffer
// Description : Directed bench for keystream_buffer. Two instances share the
//               stimulus: one holds on exhaustion, the other refills.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keystream_buffer;

  logic       clk;
  logic       rst_n;
  logic       seed_load;
  logic [7:0] seed;
  logic       req;

  logic       ready0, valid0, exh0, drop0;
  logic [7:0] data0;
  logic [2:0] left0;
  logic       ready1, valid1, exh1, drop1;
  logic [7:0] data1;
  logic [2:0] left1;

  int n_total = 0;
  int n_bad   = 0;
  int lat;
  int pulses;
  logic v0_seen;

  keystream_buffer #(.WIDTH(8), .DEPTH(4), .POLY(8'hB8), .AUTO_REFILL(1'b0)) u_hold (
    .clk(clk), .rst_n(rst_n), .seed_load_i(seed_load), .seed_i(seed), .req_i(req),
    .ready_o(ready0), .out_valid_o(valid0), .out_data_o(data0),
    .exhausted_o(exh0), .req_drop_o(drop0), .words_left_o(left0)
  );

  keystream_buffer #(.WIDTH(8), .DEPTH(4), .POLY(8'hB8), .AUTO_REFILL(1'b1)) u_refill (
    .clk(clk), .rst_n(rst_n), .seed_load_i(seed_load), .seed_i(seed), .req_i(req),
    .ready_o(ready1), .out_valid_o(valid1), .out_data_o(data1),
    .exhausted_o(exh1), .req_drop_o(drop1), .words_left_o(left1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid of the chosen instance (0=hold, 1=refill), counting
  // cycles; also records any pulse from the hold instance meanwhile.
  task automatic wait_valid(input bit sel, output int l);
    l = 0;
    v0_seen = 1'b0;
    do begin
      tick();
      l++;
      v0_seen = v0_seen | valid0;
    end while (!(sel ? valid1 : valid0) && l < 30);
  endtask

  task automatic do_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; seed_load = 1'b0; seed = 8'h00; req = 1'b0;
    tick(); tick();
    chk("rst_ready", ready0, 1);
    chk("rst_valid", valid0, 0);
    chk("rst_data", data0, 8'h00);
    chk("rst_exh", exh0, 0);
    chk("rst_drop", drop0, 0);
    chk("rst_left", left0, 0);
    rst_n = 1'b1;

    // Seed 01, first word from idle
    seed_load = 1'b1; seed = 8'h01;
    tick();
    seed_load = 1'b0;
    do_req();
    wait_valid(0, lat);
    chk("first_lat", lat, 6);
    chk("w0", data0, 8'hB8);
    chk("w0_left", left0, 3);

    do_req();
    wait_valid(0, lat);
    chk("ready_lat", lat, 2);
    chk("w1", data0, 8'h5C);
    do_req();
    wait_valid(0, lat);
    chk("w2", data0, 8'h2E);
    do_req();
    wait_valid(0, lat);
    chk("w3", data0, 8'h17);
    chk("exh_hold", exh0, 1);
    chk("exh_refill", exh1, 1);
    chk("exh_left", left0, 0);

    // Let the refilling instance finish its refill
    repeat (6) tick();
    chk("refill_left", left1, 4);
    chk("refill_ready", ready1, 1);
    chk("hold_still_exh", exh0, 1);
    chk("hold_data_held", data0, 8'h17);

    // Fifth request: dropped by the holding copy, served by the refilling one
    do_req();
    chk("drop5_hold", drop0, 1);
    chk("drop5_refill", drop1, 0);
    wait_valid(1, lat);
    chk("w4_refill", data1, 8'hB3);
    chk("w4_left", left1, 3);
    chk("hold_no_valid", v0_seen, 0);
    chk("hold_exh_after", exh0, 1);

    // Zero seed behaves as seed 01
    seed_load = 1'b1; seed = 8'h00;
    tick();
    seed_load = 1'b0;
    chk("seed0_ready", ready0, 1);
    chk("seed0_exh", exh0, 0);
    do_req();
    wait_valid(0, lat);
    chk("seed0_lat", lat, 6);
    chk("seed0_w0", data0, 8'hB8);

    // Back-to-back requests in READY: second one dropped
    req = 1'b1;
    tick();
    tick();
    req = 1'b0;
    chk("b2b_drop", drop0, 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid0) pulses++;
    end
    chk("b2b_pulses", pulses, 1);
    chk("b2b_data", data0, 8'h5C);
    chk("b2b_left", left0, 2);

    // seed_load during the pulse cycle cancels the pulse
    do_req();
    tick();
    seed_load = 1'b1; seed = 8'h01;
    tick();
    seed_load = 1'b0;
    chk("sl_valid", valid0, 0);
    chk("sl_ready", ready0, 1);
    chk("sl_left", left0, 0);
    do_req();
    wait_valid(0, lat);
    chk("sl_lat", lat, 6);
    chk("sl_w0", data0, 8'hB8);

    // Asynchronous reset in the middle of a fill
    seed_load = 1'b1; seed = 8'h5A;
    tick();
    seed_load = 1'b0;
    do_req();
    tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_data", data0, 8'h00);
    chk("arst_left", left0, 0);
    chk("arst_ready", ready0, 1);
    chk("arst_valid", valid0, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_req();
    wait_valid(0, lat);
    chk("arst_lat", lat, 6);
    chk("arst_w0", data0, 8'hB8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
